lbimat_sched: RTL and testbench
===============================

LBIMAT_SCHED -- requirements
Module: lbimat_sched

Interface
REQ-001 Parameter NUM_ROW, default 140, number of matrix rows evaluated per message.
REQ-002 Parameter NUM_ENG, default 4, number of shared row engines; range 1..8.
REQ-003 Parameter RESW, default 6, width of one engine result (row chunk sum).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port msg_vld  input  1  new message available on the datapath input bus.
REQ-007 Port msg_rdy  output  1  scheduler can accept a message.
REQ-008 Port msg_load  output  1  one-cycle pulse telling the engines to latch the message.
REQ-009 Port eng_start  output  NUM_ENG  one-hot start pulse to a row engine.
REQ-010 Port eng_row  output  8  row index for the engine pulsed on eng_start.
REQ-011 Port eng_done  input  NUM_ENG  per-engine one-cycle completion pulse.
REQ-012 Port eng_res  input  NUM_ENG*RESW  per-engine result; slice i is valid when eng_done[i]=1.
REQ-013 Port res_out  output  NUM_ROW  per-row result bit, bit r = LSB of the row r sum.
REQ-014 Port res_vld  output  1  res_out complete and stable.
REQ-015 Port res_rdy  input  1  consumer accepts res_out.
REQ-016 Port err  output  1  sticky protocol error flag.

Function
REQ-017 States: IDLE, LOAD, DISPATCH, DRAIN, OUTPUT; encoded in 3 bits.
REQ-018 IDLE: msg_rdy=1; msg_vld=1 -> LOAD next cycle; otherwise stay.
REQ-019 LOAD: msg_load=1 for exactly one cycle; row counter=0, all busy bits clear, res_out cleared; -> DISPATCH.
REQ-020 DISPATCH: each cycle, if row counter<NUM_ROW and any engine is free, the lowest-index free engine gets eng_start=1 and eng_row=row counter; the counter increments and the engine's busy bit sets and records its row.
REQ-021 At most one eng_start bit is high per cycle; eng_row is 0 when eng_start=0.
REQ-022 DISPATCH -> DRAIN in the cycle after the start for row NUM_ROW-1 is issued.
REQ-023 eng_done[i] with engine i busy: res_out[recorded row]<=eng_res slice i bit 0; busy[i] clears; several engines may complete in the same cycle and all are captured.
REQ-024 An engine whose done arrives in cycle t is free for dispatch no earlier than cycle t+1; no start and done on the same engine in the same cycle.
REQ-025 eng_done[i] with engine i not busy: ignored for res_out; err<=1 (sticky until reset).
REQ-026 DRAIN: -> OUTPUT in the cycle after all busy bits are clear.
REQ-027 OUTPUT: res_vld=1 and res_out held stable until res_rdy=1; on the res_rdy=1 cycle -> IDLE and res_vld=0 next cycle.
REQ-028 msg_vld outside IDLE is ignored; msg_rdy=0 in every state except IDLE.
REQ-029 Minimum message-to-res_vld latency with single-cycle engines and NUM_ENG>=2: NUM_ROW+3 cycles after the accepting msg_vld edge.
REQ-030 Row counter and recorded rows are 8 bits; NUM_ROW<=255.

Reset
REQ-031 reset=1 on a rising edge: state=IDLE, busy bits, row counter, res_out and err=0; msg_load, eng_start, eng_row and res_vld=0 in the following cycle.
REQ-032 Reset mid-DISPATCH or DRAIN abandons the message; eng_done arriving after reset is treated per REQ-025.

Verification
REQ-033 NUM_ROW=140, NUM_ENG=4, engines done 3 cycles after start with result = row index -> res_out[r] = r[0] (alternating 0101...), res_vld exactly once, err=0.
REQ-034 Engine 2 latency 20 cycles, others 1 -> engines 0,1,3 keep dispatch busy, every row is still started exactly once, res_out is correct, and no eng_start goes to a busy engine.
REQ-035 All 4 engines done in the same cycle -> all 4 results are captured; the next 4 starts go to engines 0,1,2,3 in consecutive cycles.
REQ-036 res_rdy held 0 for 10 cycles in OUTPUT -> res_vld and res_out are stable, msg_rdy=0, and msg_vld pulses are ignored.
REQ-037 Spurious eng_done[1] while IDLE -> err=1, and it stays 1 until reset.
REQ-038 reset asserted at row 70 of DISPATCH -> next cycle all outputs are zero and msg_rdy=1; a new message then completes normally.

Source files
------------

// File: rtl/lbimat_sched.sv
// Row-engine scheduler for the LBI matrix check: hands matrix rows to a pool of shared
// engines, collects each row's parity bit and presents the full result vector.
module lbimat_sched #(
   parameter int NUM_ROW = 140,
   parameter int NUM_ENG = 4,
   parameter int RESW    = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    msg_vld,
   output logic                    msg_rdy,
   output logic                    msg_load,
   output logic [NUM_ENG-1:0]      eng_start,
   output logic [7:0]              eng_row,
   input  logic [NUM_ENG-1:0]      eng_done,
   input  logic [NUM_ENG*RESW-1:0] eng_res,
   output logic [NUM_ROW-1:0]      res_out,
   output logic                    res_vld,
   input  logic                    res_rdy,
   output logic                    err
);

   typedef enum logic [2:0] {IDLE, LOAD, DISPATCH, DRAIN, OUTPUT} stateT;

   localparam logic [7:0] ROW_LIMIT = 8'(NUM_ROW);
   localparam logic [7:0] LAST_ROW  = 8'(NUM_ROW - 1);

   stateT               r_state;
   logic [7:0]          r_rowCnt;
   logic [NUM_ENG-1:0]  r_busy;
   logic [7:0]          r_rowOf [NUM_ENG];
   logic [NUM_ROW-1:0]  r_resOut;
   logic                r_err;

   logic [NUM_ENG-1:0]  w_start;
   logic                w_found;
   logic [NUM_ENG-1:0]  w_spurious;
   logic                w_unusedRes;

   // Lowest-index free engine wins; busy reflects last cycle's done, so a freed engine waits one cycle.
   always_comb begin
      w_start = '0;
      w_found = 1'b0;
      if (r_state == DISPATCH && r_rowCnt < ROW_LIMIT) begin
         for (int i = 0; i < NUM_ENG; i++) begin
            if (!r_busy[i] && !w_found) begin
               w_start[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
      end
   end

   assign w_spurious = eng_done & ~r_busy;
   // Only the parity bit of each engine sum is consumed.
   assign w_unusedRes = ^eng_res;

   assign msg_rdy   = (r_state == IDLE);
   assign msg_load  = (r_state == LOAD);
   assign res_vld   = (r_state == OUTPUT);
   assign eng_start = w_start;
   assign eng_row   = w_found ? r_rowCnt : 8'd0;
   assign res_out   = r_resOut;
   assign err       = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_rowCnt <= '0;
         r_busy   <= '0;
         r_resOut <= '0;
         r_err    <= 1'b0;
         for (int i = 0; i < NUM_ENG; i++) r_rowOf[i] <= '0;
      end else begin
         if (|w_spurious) r_err <= 1'b1;

         for (int i = 0; i < NUM_ENG; i++) begin
            if (w_start[i]) r_rowOf[i] <= r_rowCnt;
         end

         if (r_state == LOAD) begin
            r_busy   <= '0;
            r_resOut <= '0;
         end else begin
            r_busy <= (r_busy & ~eng_done) | w_start;
            for (int i = 0; i < NUM_ENG; i++) begin
               if (eng_done[i] && r_busy[i]) r_resOut[r_rowOf[i]] <= eng_res[i*RESW];
            end
         end

         case (r_state)
            IDLE: begin
               if (msg_vld) r_state <= LOAD;
            end
            LOAD: begin
               r_rowCnt <= '0;
               r_state  <= DISPATCH;
            end
            DISPATCH: begin
               if (w_found) begin
                  r_rowCnt <= r_rowCnt + 8'd1;
                  if (r_rowCnt == LAST_ROW) r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (r_busy == '0) r_state <= OUTPUT;
            end
            OUTPUT: begin
               if (res_rdy) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lbimat_sched.sv
// Bench for lbimat_sched: behavioural row engines with per-engine latency, plus directed
// message scenarios with hand-derived expected results.
module tb_lbimat_sched;

   localparam int NR = 140;
   localparam int NE = 4;
   localparam int RW = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic             msg_vld;
   logic             msg_rdy;
   logic             msg_load;
   logic [NE-1:0]    eng_start;
   logic [7:0]       eng_row;
   logic [NE-1:0]    eng_done;
   logic [NE*RW-1:0] eng_res;
   logic [NR-1:0]    res_out;
   logic             res_vld;
   logic             res_rdy;
   logic             err;

   lbimat_sched #(.NUM_ROW(NR), .NUM_ENG(NE), .RESW(RW)) dut (
      .clk       (clk),
      .reset     (reset),
      .msg_vld   (msg_vld),
      .msg_rdy   (msg_rdy),
      .msg_load  (msg_load),
      .eng_start (eng_start),
      .eng_row   (eng_row),
      .eng_done  (eng_done),
      .eng_res   (eng_res),
      .res_out   (res_out),
      .res_vld   (res_vld),
      .res_rdy   (res_rdy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int passCount  = 0;
   int checkCount = 0;

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Engine model: result is the row index (optionally with LSB flipped), done after lat[i] cycles.
   int         lat [NE];
   int         cnt [NE];
   logic [7:0] rowReg [NE];
   logic       holdAll   = 1'b0;
   logic       resXor    = 1'b0;
   logic [3:0] forceDone = 4'b0;

   always @(posedge clk) begin
      for (int i = 0; i < NE; i++) begin
         if (reset) begin
            cnt[i]    <= 0;
            rowReg[i] <= 8'd0;
         end else if (eng_start[i]) begin
            cnt[i]    <= lat[i];
            rowReg[i] <= eng_row;
         end else if (cnt[i] > 1 || (cnt[i] == 1 && !holdAll)) begin
            cnt[i] <= cnt[i] - 1;
         end
      end
   end

   always_comb begin
      eng_done = forceDone;
      eng_res  = '0;
      for (int i = 0; i < NE; i++) begin
         if (cnt[i] == 1 && !holdAll) eng_done[i] = 1'b1;
         eng_res[i*RW +: RW] = rowReg[i][RW-1:0] ^ RW'(resXor);
      end
   end

   // Protocol monitor: start counts per row, illegal starts, result-valid pulses.
   int   startCnt [256];
   int   viol      = 0;
   int   vldCount  = 0;
   int   loadCount = 0;
   logic prevVld   = 1'b0;

   always @(negedge clk) begin
      if (msg_load) begin
         loadCount++;
         vldCount = 0;
         for (int r = 0; r < 256; r++) startCnt[r] = 0;
      end
      if (res_vld && !prevVld) vldCount++;
      prevVld = res_vld;
      if (eng_start != '0) begin
         if (!$onehot(eng_start)) viol++;
         for (int i = 0; i < NE; i++) begin
            if (eng_start[i] && cnt[i] != 0) viol++;
         end
         startCnt[eng_row]++;
      end else if (eng_row != 8'd0) begin
         viol++;
      end
   end

   task automatic sendMessage(input logic xorVal);
      @(negedge clk);
      resXor  = xorVal;
      msg_vld = 1'b1;
      @(negedge clk);
      msg_vld = 1'b0;
   endtask

   task automatic waitResult(output int n, output logic [NR-1:0] snap);
      n = 0;
      while (!res_vld && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!res_vld) checkOutput("vld_timeout", 0, 1);
      snap = res_out;
   endtask

   task automatic acceptResult(input int holdCycles, input logic [NR-1:0] snap);
      int unstable = 0;
      int rdyBad   = 0;
      for (int k = 0; k < holdCycles; k++) begin
         msg_vld = (k % 2 == 0);
         @(negedge clk);
         if (res_out !== snap || res_vld !== 1'b1) unstable++;
         if (msg_rdy !== 1'b0) rdyBad++;
      end
      msg_vld = 1'b0;
      if (holdCycles > 0) begin
         checkOutput("hold_stable", unstable, 0);
         checkOutput("hold_msg_rdy", rdyBad, 0);
      end
      res_rdy = 1'b1;
      @(negedge clk);
      res_rdy = 1'b0;
      checkOutput("vld_drop", {res_vld, msg_rdy}, 2'b01);
   endtask

   task automatic checkMessage(input logic xorVal, input logic [NR-1:0] snap);
      logic [NR-1:0] exp;
      int badRows = 0;
      for (int r = 0; r < NR; r++) exp[r] = r[0] ^ xorVal;
      for (int r = 0; r < 256; r++) begin
         if (startCnt[r] != ((r < NR) ? 1 : 0)) badRows++;
      end
      checkOutput("res_out", snap, exp);
      checkOutput("starts_once", badRows, 0);
      checkOutput("vld_once", vldCount, 1);
      checkOutput("no_busy_start", viol, 0);
      checkOutput("err_clear", err, 0);
   endtask

   task automatic applyStimulus(input int holdCycles, input logic xorVal, output int latency);
      logic [NR-1:0] snap;
      sendMessage(xorVal);
      waitResult(latency, snap);
      acceptResult(holdCycles, snap);
      checkMessage(xorVal, snap);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int            latA, latB, latC, latE, n;
      logic [15:0]   seqBits;
      logic [31:0]   rowBits;
      logic [NR-1:0] snap;

      reset   = 1'b1;
      msg_vld = 1'b0;
      res_rdy = 1'b0;
      lat     = '{3, 3, 3, 3};
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_outputs", {msg_rdy, msg_load, eng_start, eng_row, res_vld, err}, 16'h8000);
      checkOutput("rst_res_out", res_out, 0);

      // Uniform 3-cycle engines, result held 10 cycles with msg_vld chatter.
      applyStimulus(10, 1'b0, latA);

      // Single-cycle engines give the minimum latency.
      lat = '{1, 1, 1, 1};
      applyStimulus(0, 1'b1, latB);
      checkOutput("latency", latB, NR + 3);

      // One slow engine among fast ones.
      lat = '{1, 1, 20, 1};
      applyStimulus(0, 1'b0, latC);

      // All four engines complete together, then restart in index order.
      lat     = '{3, 3, 3, 3};
      holdAll = 1'b1;
      sendMessage(1'b1);
      n = 0;
      while (!(cnt[0] == 1 && cnt[1] == 1 && cnt[2] == 1 && cnt[3] == 1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      holdAll = 1'b0;
      seqBits = '0;
      rowBits = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         seqBits = {seqBits[11:0], eng_start};
         rowBits = {rowBits[23:0], eng_row};
      end
      checkOutput("simul_starts", seqBits, 16'h1248);
      checkOutput("simul_rows", rowBits, 32'h04050607);
      waitResult(n, snap);
      acceptResult(0, snap);
      checkMessage(1'b1, snap);
      checkOutput("load_count", loadCount, 4);

      // Spurious done while idle sets a sticky error.
      @(negedge clk);
      forceDone = 4'b0010;
      @(negedge clk);
      forceDone = 4'b0000;
      checkOutput("err_set", err, 1);
      repeat (5) @(negedge clk);
      checkOutput("err_sticky", {err, msg_rdy}, 2'b11);

      // Reset in the middle of dispatch, then a clean message.
      sendMessage(1'b0);
      n = 0;
      while (!(eng_start != '0 && eng_row == 8'd70) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("row70_seen", eng_row, 70);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midrst_outputs", {msg_rdy, msg_load, eng_start, eng_row, res_vld, err}, 16'h8000);
      checkOutput("midrst_res_out", res_out, 0);
      repeat (6) @(negedge clk);
      checkOutput("midrst_err", err, 0);
      applyStimulus(0, 1'b1, latE);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
